// File: rtl/tmds_period_scheduler.sv
// Schedules TMDS encoders through control, preamble, guard-band and video periods behind a fixed pixel delay.
// Define TMDS_HDMI_MODE_EN for HDMI preamble/guard-band generation; the default build is DVI (control/video only).
module tmds_period_scheduler #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       active_draw_in,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out,
    output logic       ve_out,
    output logic [1:0] ctrl_blue_out,
    output logic [1:0] ctrl_green_out,
    output logic [1:0] ctrl_red_out,
    output logic       guard_out,
    output logic [9:0] gb_blue_out,
    output logic [9:0] gb_green_out,
    output logic [9:0] gb_red_out,
    output logic       short_blank_out
);
    localparam int D  = PREAMBLE_LEN + GUARD_LEN;
    localparam int W  = 27;
    localparam int DE = 26;
    localparam int HS = 25;
    localparam int VS = 24;

    // Word layout: {de, hs, vs, red, green, blue}
    logic [W-1:0] sample_q;
    logic [W-1:0] dly_q [D];
    logic         lead_de;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sample_q <= '0;
            for (int i = 0; i < D; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            sample_q <= {active_draw_in, h_sync_in, v_sync_in, red_in, green_in, blue_in};
            dly_q[0] <= sample_q;
            for (int i = 1; i < D; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // DE of the word about to enter the tail, so state_q stays aligned with the tail word.
    generate
        if (D >= 2) begin : g_lead
            assign lead_de = dly_q[D-2][DE];
        end else begin : g_lead_short
            assign lead_de = sample_q[DE];
        end
    endgenerate

    logic [23:0] pix_q;
    logic        ve_q;
    logic        ve_d;
    logic [1:0]  ctrl_blue_q;
    logic [1:0]  ctrl_blue_d;

`ifdef TMDS_HDMI_MODE_EN
    localparam int         MAXLEN = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int         CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam logic [9:0] GB_BR  = 10'b1011001100;
    localparam logic [9:0] GB_G   = 10'b0100110011;

    typedef enum logic [1:0] {ST_CTRL, ST_PRE, ST_GB, ST_VID} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ctrl_green_q, ctrl_green_d;
    logic          guard_q, guard_d;
    logic          short_q, short_d;
    logic          rise;

    assign rise = active_draw_in & ~sample_q[DE];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ve_d         = 1'b0;
        ctrl_blue_d  = {dly_q[D-1][VS], dly_q[D-1][HS]};
        ctrl_green_d = 2'b00;
        guard_d      = 1'b0;
        short_d      = 1'b0;
        case (state_q)
            ST_CTRL: begin
                if (rise) begin
                    state_d = ST_PRE;
                    cnt_d   = CW'(PREAMBLE_LEN - 1);
                end
            end
            ST_PRE: begin
                ctrl_green_d = 2'b01;
                if (cnt_q == '0) begin
                    state_d = ST_GB;
                    cnt_d   = CW'(GUARD_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GB: begin
                ctrl_green_d = 2'b01;
                guard_d      = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_VID;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_VID: begin
                ve_d        = 1'b1;
                ctrl_blue_d = 2'b00;
                if (!lead_de) begin
                    state_d = ST_CTRL;
                end
            end
            default: state_d = ST_CTRL;
        endcase
        // Active video overrides any sequence in progress.
        if (lead_de) begin
            state_d = ST_VID;
        end
        // A line start arriving mid-sequence cannot get its own preamble.
        if (rise && state_q != ST_CTRL) begin
            short_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_CTRL;
            cnt_q        <= '0;
            ctrl_green_q <= 2'b00;
            guard_q      <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_green_q <= ctrl_green_d;
            guard_q      <= guard_d;
            short_q      <= short_d;
        end
    end

    assign ctrl_green_out  = ctrl_green_q;
    assign guard_out       = guard_q;
    assign gb_blue_out     = guard_q ? GB_BR : 10'd0;
    assign gb_red_out      = guard_q ? GB_BR : 10'd0;
    assign gb_green_out    = guard_q ? GB_G  : 10'd0;
    assign short_blank_out = short_q;
`else
    typedef enum logic {ST_CTRL, ST_VID} state_t;

    state_t state_q, state_d;

    always_comb begin
        state_d     = state_q;
        ve_d        = 1'b0;
        ctrl_blue_d = {dly_q[D-1][VS], dly_q[D-1][HS]};
        case (state_q)
            ST_CTRL: begin
                if (lead_de) begin
                    state_d = ST_VID;
                end
            end
            ST_VID: begin
                ve_d        = 1'b1;
                ctrl_blue_d = 2'b00;
                if (!lead_de) begin
                    state_d = ST_CTRL;
                end
            end
            default: state_d = ST_CTRL;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_CTRL;
        end else begin
            state_q <= state_d;
        end
    end

    assign ctrl_green_out  = 2'b00;
    assign guard_out       = 1'b0;
    assign gb_blue_out     = 10'd0;
    assign gb_red_out      = 10'd0;
    assign gb_green_out    = 10'd0;
    assign short_blank_out = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pix_q       <= '0;
            ve_q        <= 1'b0;
            ctrl_blue_q <= 2'b00;
        end else begin
            pix_q       <= dly_q[D-1][23:0];
            ve_q        <= ve_d;
            ctrl_blue_q <= ctrl_blue_d;
        end
    end

    assign red_out       = pix_q[23:16];
    assign green_out     = pix_q[15:8];
    assign blue_out      = pix_q[7:0];
    assign ve_out        = ve_q;
    assign ctrl_blue_out = ctrl_blue_q;
    assign ctrl_red_out  = 2'b00;

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// Scoreboard bench for tmds_period_scheduler: directed lines, short blanking, async reset; HDMI or DVI build.
`timescale 1ns/1ps
module tb_tmds_period_scheduler;
    localparam int LAT  = 11;
    localparam int PRE  = 8;
    localparam int GRD  = 2;
    localparam int NMAX = 1024;
`ifdef TMDS_HDMI_MODE_EN
    localparam bit HDMI = 1'b1;
`else
    localparam bit HDMI = 1'b0;
`endif
    localparam logic [9:0] GB_BR = 10'b1011001100;
    localparam logic [9:0] GB_G  = 10'b0100110011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       active_draw = 1'b0;
    logic       h_sync = 1'b0;
    logic       v_sync = 1'b0;
    logic [7:0] red_i = 8'd0, green_i = 8'd0, blue_i = 8'd0;
    logic [7:0] red_o, green_o, blue_o;
    logic       ve_o, guard_o, short_o;
    logic [1:0] cb_o, cg_o, cr_o;
    logic [9:0] gbb_o, gbg_o, gbr_o;

    always #5 clk = ~clk;

    tmds_period_scheduler dut (
        .clk_in(clk), .rst_in(rst),
        .active_draw_in(active_draw), .h_sync_in(h_sync), .v_sync_in(v_sync),
        .red_in(red_i), .green_in(green_i), .blue_in(blue_i),
        .red_out(red_o), .green_out(green_o), .blue_out(blue_o),
        .ve_out(ve_o), .ctrl_blue_out(cb_o), .ctrl_green_out(cg_o), .ctrl_red_out(cr_o),
        .guard_out(guard_o), .gb_blue_out(gbb_o), .gb_green_out(gbg_o), .gb_red_out(gbr_o),
        .short_blank_out(short_o)
    );

    typedef struct {
        int          e;
        logic        ve;
        logic [1:0]  blue, green, red;
        logic        guard;
        logic [9:0]  gbb, gbg, gbr;
        logic        sb;
        logic [23:0] pix;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_x;
    logic        ve_t    [NMAX];
    logic [1:0]  sync_t  [NMAX];
    logic [23:0] pix_t   [NMAX];
    logic        pre_t   [NMAX];
    logic        guard_t [NMAX];
    logic        short_t [NMAX];
    int          edge_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic        prev_de = 1'b0;
    int          kind = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s edge=%0d actual=%h required=%h", name, e, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ve"}, edge_cnt, 32'(ve_o), 0);
        chk({tag, "_cb"}, edge_cnt, 32'(cb_o), 0);
        chk({tag, "_cg"}, edge_cnt, 32'(cg_o), 0);
        chk({tag, "_cr"}, edge_cnt, 32'(cr_o), 0);
        chk({tag, "_guard"}, edge_cnt, 32'(guard_o), 0);
        chk({tag, "_gb"}, edge_cnt, {2'b00, gbb_o, gbg_o, gbr_o}, 0);
        chk({tag, "_short"}, edge_cnt, 32'(short_o), 0);
        chk({tag, "_pix"}, edge_cnt, {8'h00, red_o, green_o, blue_o}, 0);
    endtask

    // Monitor: compares the DUT outputs after each edge with the record queued for that edge.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].e <= edge_cnt) begin
            mon_x = sbq.pop_front();
            if (mon_x.e != edge_cnt) begin
                total++;
                bad++;
                $display("FAIL missed_record edge=%0d actual=%0d required=%0d", mon_x.e, edge_cnt, mon_x.e);
            end else begin
                chk("ve", mon_x.e, 32'(ve_o), 32'(mon_x.ve));
                chk("ctrl_blue", mon_x.e, 32'(cb_o), 32'(mon_x.blue));
                chk("ctrl_green", mon_x.e, 32'(cg_o), 32'(mon_x.green));
                chk("ctrl_red", mon_x.e, 32'(cr_o), 32'(mon_x.red));
                chk("guard", mon_x.e, 32'(guard_o), 32'(mon_x.guard));
                chk("gb_words", mon_x.e, {2'b00, gbb_o, gbg_o, gbr_o}, {2'b00, mon_x.gbb, mon_x.gbg, mon_x.gbr});
                chk("short_blank", mon_x.e, 32'(short_o), 32'(mon_x.sb));
                chk("pixel", mon_x.e, {8'h00, red_o, green_o, blue_o}, {8'h00, mon_x.pix});
            end
        end
    end

    // Drives one input word for the next edge and queues the expected outputs for that edge.
    task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] pix);
        int   e;
        exp_t x;
        e = edge_cnt + 1;
        active_draw = de;
        h_sync      = hs;
        v_sync      = vs;
        {red_i, green_i, blue_i} = pix;
        ve_t[e+LAT]   = de;
        sync_t[e+LAT] = {vs, hs};
        pix_t[e+LAT]  = pix;
        if (de && !prev_de) begin
            if (HDMI && kind == 1) begin
                for (int k = 1; k <= PRE + GRD; k++) begin
                    pre_t[e+k]   = 1'b1;
                    guard_t[e+k] = (k > PRE);
                end
            end
            if (HDMI && kind == 2) short_t[e] = 1'b1;
            $display("line start edge=%0d kind=%0d first_pixel_edge=%0d", e, kind, e + LAT);
        end
        prev_de = de;
        x.e     = e;
        x.ve    = ve_t[e];
        x.pix   = pix_t[e];
        x.blue  = ve_t[e] ? 2'b00 : sync_t[e];
        x.green = (!ve_t[e] && pre_t[e]) ? 2'b01 : 2'b00;
        x.red   = 2'b00;
        x.guard = guard_t[e];
        x.gbb   = guard_t[e] ? GB_BR : 10'd0;
        x.gbr   = guard_t[e] ? GB_BR : 10'd0;
        x.gbg   = guard_t[e] ? GB_G : 10'd0;
        x.sb    = short_t[e];
        sbq.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic blank(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            step(1'b0, ((i + seed) % 6) < 2, ((i + seed) % 13) >= 9, 24'h400000 + 24'(i * 17 + seed));
        end
    endtask

    task automatic line(input int n, input int k);
        kind = k;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, {8'(i * 3 + k), 8'(i * 5 + 1), 8'(i * 7 + 2)});
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog edge=%0d actual=running required=finished", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NMAX; i++) begin
            ve_t[i] = 1'b0; sync_t[i] = 2'b00; pix_t[i] = 24'd0;
            pre_t[i] = 1'b0; guard_t[i] = 1'b0; short_t[i] = 1'b0;
        end
        #1 rst = 1'b1;
        #1 check_all_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;

        blank(40, 0);
        line(20, 1);
        blank(11, 3);
        line(20, 1);
        blank(5, 1);
        line(12, 2);
        blank(30, 2);
        line(4, 1);

        // Reset in the middle of a preamble, between clock edges.
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_pre");
        active_draw = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
        {red_i, green_i, blue_i} = 24'd0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_mid_held");
        rst = 1'b0;
        for (int x = edge_cnt + 1; x <= edge_cnt + LAT + PRE + GRD; x++) begin
            ve_t[x] = 1'b0; sync_t[x] = 2'b00; pix_t[x] = 24'd0;
            pre_t[x] = 1'b0; guard_t[x] = 1'b0; short_t[x] = 1'b0;
        end
        prev_de = 1'b0;
        $display("reset released edge=%0d", edge_cnt);

        blank(15, 4);
        line(16, 1);
        blank(14, 5);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", edge_cnt, 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tmds_period_scheduler.md
# tmds_period_scheduler

Sequences the three per-channel TMDS encoders (blue = ch0, green = ch1, red = ch2) through the HDMI control, video-preamble, video-guard-band and video-data periods. It sits between the video timing/pixel pipeline and the encoders. It delays pixel data and syncs by a fixed latency so it can look ahead to each active-video start. It drives each encoder's `ve_in` and `control_in`, and flags guard-band cycles so the downstream serializer mux substitutes the guard words.

## Interface
- `PREAMBLE_LEN`, default 8: preamble cycles before each active line.
- `GUARD_LEN`, default 2: leading guard-band cycles.
- Derived: `D = PREAMBLE_LEN + GUARD_LEN`; latency `L = D + 1`.

Ports:
- `clk_in` in 1: pixel clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `active_draw_in` in 1: raw data enable (DE).
- `h_sync_in` in 1: raw hsync.
- `v_sync_in` in 1: raw vsync.
- `red_in`, `green_in`, `blue_in` in 8 each: pixel data.
- `red_out`, `green_out`, `blue_out` out 8 each: delayed pixel data to encoders.
- `ve_out` out 1: video enable to all three encoders.
- `ctrl_blue_out` out 2: `{vs,hs}` to ch0 encoder.
- `ctrl_green_out` out 2: `{CTL1,CTL0}` to ch1 encoder.
- `ctrl_red_out` out 2: `{CTL3,CTL2}` to ch2 encoder.
- `guard_out` out 1: guard-band cycle; downstream mux selects `gb_*_out`.
- `gb_blue_out`, `gb_green_out`, `gb_red_out` out 10 each: guard words, 0 when `guard_out` = 0.
- `short_blank_out` out 1: one-cycle pulse when a line start arrives too early for its preamble.

## Operation
- Delay line of depth `D` carries `{active_draw_in, h_sync_in, v_sync_in, rgb}`, followed by one output register. Every pixel and sync reaches the outputs exactly `L` edges after sampling. Data is never dropped or reordered.
- Raw rising edge: `active_draw_in`=1 and the previous sample = 0, detected on the input side.
- FSM states and transitions:
  - CTRL → PRE on a raw rising edge; load counter `PREAMBLE_LEN-1`.
  - PRE → GB when the counter reaches 0; load `GUARD_LEN-1`.
  - GB → VID when the counter reaches 0. This coincides with the delayed DE going high.
  - VID → CTRL when the delayed DE goes low.
  - Any state → VID whenever the delayed DE = 1. Video always wins.
- Outputs by state:
  - CTRL: `ve_out`=0; blue ctrl = delayed `{vs,hs}`; green = 00; red = 00; `guard_out`=0.
  - PRE: `ve_out`=0; blue = delayed `{vs,hs}`; green = 2'b01 (CTL0=1, video preamble); red = 2'b00.
  - GB: `ve_out`=0; `guard_out`=1; ctrl held at PRE values; `gb_blue_out` = `gb_red_out` = 10'b1011001100, `gb_green_out` = 10'b0100110011.
  - VID: `ve_out`=1; all ctrl = 00; `guard_out`=0.
- Short blank:
  - A raw rising edge while FSM is in VID, PRE or GB does not restart the sequence. `short_blank_out` pulses for 1 cycle.
  - That line enters VID directly from CTRL when its delayed DE rises, with no preamble or guard band.
  - Guaranteed preamble requires raw DE low for ≥ `L` cycles.
- The pixel bus `*_out` always carries delayed data, including outside VID. The encoders ignore it there.

## Timing
- Raw rising edge sampled at edge n:
  - Preamble is visible after edges n+1 … n+`PREAMBLE_LEN`.
  - Guard band is visible after edges n+`PREAMBLE_LEN`+1 … n+`D`.
  - First video pixel is visible after edge n+`L`.
- Raw DE falling at edge f: CTRL is visible after edge f+`L`. No trailing guard band.
- Reset is asynchronous and clears immediately:
  - All outputs 0 (`ve_out`, ctrl, `guard_out`, `gb_*`, `short_blank_out`, pixel outputs).
  - FSM = CTRL, delay line cleared.
  - After release, the first `L` output cycles are CTRL with `{vs,hs}`=00.
- Reset mid-line: the partial preamble or video is abandoned; no `short_blank_out` is generated at release.
- Counter widths: `$clog2(max(PREAMBLE_LEN,GUARD_LEN))`. Counters do not wrap past 0.

## Configuration
- `TMDS_HDMI_MODE_EN` defined: HDMI behaviour as above.
- Undefined (DVI mode):
  - PRE and GB states are removed; FSM is CTRL/VID only.
  - green/red ctrl are always 00; `guard_out` and `gb_*_out` tied 0; `short_blank_out` tied 0.
  - Latency stays `L` so downstream alignment is unchanged.

## Test plan
- Reset, then a 20-pixel line after 40 blank cycles, rising edge at edge n → `ctrl_green_out`=01 for edges n+1..n+8; `guard_out`=1 with gb words B3/133-pattern at n+9..n+10; `ve_out`=1 with first pixel at n+11 through n+30; CTRL at n+31.
- hs/vs toggling during blanking → `ctrl_blue_out` equals input `{vs,hs}` delayed exactly 11 cycles, including during PRE/GB.
- Blanking of 5 cycles between lines → `short_blank_out` single pulse; second line has no PRE/GB; its pixels appear at the correct latency with no gap.
- Async `rst_in` asserted mid-preamble (no clock edge) → all outputs 0 immediately; after release, 11 cycles of CTRL before any new sequence.
- Back-to-back lines with exactly 11-cycle blanking → full 8+2 preamble/guard, no `short_blank_out`.
- Build without `TMDS_HDMI_MODE_EN` → same stimulus as the first scenario yields green ctrl 00 throughout, `guard_out`=0, video still at n+11.
